// File: rtl/regfile_scoreboard_if.sv
// Register file / scoreboard bus: write port, two read ports, issue port and flush control.
// The pipeline side drives through master; the register file sits behind slave.
interface regfile_scoreboard_if #(
  parameter int DataWidth  = 32,
  parameter int RegAddress = 5
);
  logic                  write_enable;
  logic [RegAddress-1:0] writedata_add;
  logic [DataWidth-1:0]  write_data;
  logic [RegAddress-1:0] source1;
  logic [RegAddress-1:0] source2;
  logic [DataWidth-1:0]  readdata1;
  logic [DataWidth-1:0]  readdata2;
  logic                  issue_valid;
  logic [RegAddress-1:0] issue_rd;
  logic                  pending1;
  logic                  pending2;
  logic                  pending_rd;
  logic                  clear_req;
  logic                  clear_busy;

  modport master (
    output write_enable, writedata_add, write_data, source1, source2,
           issue_valid, issue_rd, clear_req,
    input  readdata1, readdata2, pending1, pending2, pending_rd, clear_busy
  );

  modport slave (
    input  write_enable, writedata_add, write_data, source1, source2,
           issue_valid, issue_rd, clear_req,
    output readdata1, readdata2, pending1, pending2, pending_rd, clear_busy
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Integer register file with hardwired x0, optional write bypass, per-register
// pending scoreboard and a one-register-per-cycle flush engine.
module regfile_scoreboard #(
  parameter int DataWidth  = 32,
  parameter int RegAddress = 5,
  parameter int NumRegs    = 2**RegAddress,
  parameter int Bypass     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_scoreboard_if.slave   bus
);

  localparam int IdxW = RegAddress + 1;
  localparam logic [IdxW-1:0] NumRegsW = IdxW'(NumRegs);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(NumRegs - 1);
  localparam logic BypassEn = (Bypass != 0);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t state_reg, state_next;
  logic [IdxW-1:0] flush_idx_reg, flush_idx_next;
  logic [DataWidth-1:0] regs_reg [NumRegs];
  logic [NumRegs-1:0] pending_reg;

  logic wr_go;
  logic iss_go;
  logic idle;
  logic busy;
  logic [NumRegs-1:0] wr_hit;
  logic [NumRegs-1:0] iss_hit;
  logic [NumRegs-1:0] flush_hit;

  function automatic logic in_range(input logic [RegAddress-1:0] idx);
    return {1'b0, idx} < NumRegsW;
  endfunction

  assign idle = (state_reg == IDLE);
  assign busy = (state_reg == CLEAR);

  // A clear request in IDLE wins over any same-cycle write or issue.
  always_comb begin
    state_next     = state_reg;
    flush_idx_next = flush_idx_reg;
    wr_go          = 1'b0;
    iss_go         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.clear_req) begin
          state_next     = CLEAR;
          flush_idx_next = IdxW'(1);
        end else begin
          wr_go  = bus.write_enable && (bus.writedata_add != '0) && in_range(bus.writedata_add);
          iss_go = bus.issue_valid && (bus.issue_rd != '0) && in_range(bus.issue_rd);
        end
      end
      CLEAR: begin
        flush_idx_next = flush_idx_reg + IdxW'(1);
        if (flush_idx_reg == LastIdx) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      flush_idx_reg <= '0;
    end else begin
      state_reg     <= state_next;
      flush_idx_reg <= flush_idx_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NumRegs; gi++) begin : g_decode
      if (gi == 0) begin : g_zero
        assign wr_hit[gi]    = 1'b0;
        assign iss_hit[gi]   = 1'b0;
        assign flush_hit[gi] = 1'b0;
      end else begin : g_reg
        assign wr_hit[gi]    = wr_go && (bus.writedata_add == RegAddress'(gi));
        assign iss_hit[gi]   = iss_go && (bus.issue_rd == RegAddress'(gi));
        assign flush_hit[gi] = busy && (flush_idx_reg == IdxW'(gi));
      end
    end
  endgenerate

  // Issue beats write on the same register: the newer producer stays outstanding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_reg[i] <= '0;
      end
      pending_reg <= '0;
    end else begin
      for (int i = 0; i < NumRegs; i++) begin
        if (flush_hit[i]) begin
          regs_reg[i]    <= '0;
          pending_reg[i] <= 1'b0;
        end else begin
          if (wr_hit[i]) begin
            regs_reg[i] <= bus.write_data;
          end
          if (iss_hit[i]) begin
            pending_reg[i] <= 1'b1;
          end else if (wr_hit[i]) begin
            pending_reg[i] <= 1'b0;
          end
        end
      end
    end
  end

  logic [RegAddress-1:0] src [2];
  logic [DataWidth-1:0]  rdata [2];
  logic [1:0]            pend_out;

  assign src[0] = bus.source1;
  assign src[1] = bus.source2;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_read
      logic byp;
      logic [DataWidth-1:0] raw;
      logic praw;

      assign byp = BypassEn && rst && idle && bus.write_enable &&
                   (bus.writedata_add == src[gi]) && (src[gi] != '0) && in_range(src[gi]);
      assign raw  = in_range(src[gi]) ? regs_reg[src[gi]] : '0;
      assign praw = in_range(src[gi]) && pending_reg[src[gi]];

      assign rdata[gi]    = !rst ? '0 : (byp ? bus.write_data : raw);
      assign pend_out[gi] = !rst ? 1'b0 : (busy ? 1'b1 : (praw && !byp));
    end
  endgenerate

  assign bus.readdata1  = rdata[0];
  assign bus.readdata2  = rdata[1];
  assign bus.pending1   = pend_out[0];
  assign bus.pending2   = pend_out[1];
  assign bus.pending_rd = !rst ? 1'b0 :
                          (busy ? 1'b1 : (in_range(bus.issue_rd) && pending_reg[bus.issue_rd]));
  assign bus.clear_busy = busy;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized and directed bench for regfile_scoreboard, checked against an
// array-based reference model; a second instance runs with bypass disabled.
module tb_regfile_scoreboard;
  localparam int DW = 32;
  localparam int RA = 5;
  localparam int NR = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_scoreboard_if #(.DataWidth(DW), .RegAddress(RA)) bus ();
  regfile_scoreboard_if #(.DataWidth(DW), .RegAddress(RA)) bus_nb ();

  assign bus_nb.write_enable  = bus.write_enable;
  assign bus_nb.writedata_add = bus.writedata_add;
  assign bus_nb.write_data    = bus.write_data;
  assign bus_nb.source1       = bus.source1;
  assign bus_nb.source2       = bus.source2;
  assign bus_nb.issue_valid   = bus.issue_valid;
  assign bus_nb.issue_rd      = bus.issue_rd;
  assign bus_nb.clear_req     = bus.clear_req;

  regfile_scoreboard #(.DataWidth(DW), .RegAddress(RA), .NumRegs(NR), .Bypass(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  regfile_scoreboard #(.DataWidth(DW), .RegAddress(RA), .NumRegs(NR), .Bypass(0)) dut_nb (
    .clk (clk),
    .rst (rst),
    .bus (bus_nb)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Reference model: plain arrays plus a flush countdown.
  logic [31:0] mdl_regs [NR];
  bit          mdl_pend [NR];
  bit          mdl_busy;
  int          mdl_pos;
  logic        obs_busy;

  function automatic void mdl_reset();
    for (int i = 0; i < NR; i++) begin
      mdl_regs[i] = '0;
      mdl_pend[i] = 1'b0;
    end
    mdl_busy = 1'b0;
    mdl_pos  = 0;
  endfunction

  task automatic cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] s1, input logic [4:0] s2,
                       input logic iv, input logic [4:0] ird, input logic cr);
    logic byp1, byp2;
    logic [31:0] e1, e2;
    logic ep1, ep2, eprd;
    bus.write_enable  = we;
    bus.writedata_add = wa;
    bus.write_data    = wd;
    bus.source1       = s1;
    bus.source2       = s2;
    bus.issue_valid   = iv;
    bus.issue_rd      = ird;
    bus.clear_req     = cr;
    @(negedge clk);
    byp1 = !mdl_busy && we && (wa == s1) && (s1 != 0);
    byp2 = !mdl_busy && we && (wa == s2) && (s2 != 0);
    e1   = byp1 ? wd : mdl_regs[s1];
    e2   = byp2 ? wd : mdl_regs[s2];
    ep1  = mdl_busy ? 1'b1 : (byp1 ? 1'b0 : mdl_pend[s1]);
    ep2  = mdl_busy ? 1'b1 : (byp2 ? 1'b0 : mdl_pend[s2]);
    eprd = mdl_busy ? 1'b1 : mdl_pend[ird];
    check_value("readdata1", bus.readdata1, e1);
    check_value("readdata2", bus.readdata2, e2);
    check_value("pending1", {31'b0, bus.pending1}, {31'b0, ep1});
    check_value("pending2", {31'b0, bus.pending2}, {31'b0, ep2});
    check_value("pending_rd", {31'b0, bus.pending_rd}, {31'b0, eprd});
    check_value("clear_busy", {31'b0, bus.clear_busy}, {31'b0, mdl_busy});
    check_value("nobyp_readdata1", bus_nb.readdata1, mdl_regs[s1]);
    check_value("nobyp_pending1", {31'b0, bus_nb.pending1},
                {31'b0, mdl_busy ? 1'b1 : mdl_pend[s1]});
    obs_busy = bus.clear_busy;
    $display("cyc we=%0b wa=%0d wd=%h s1=%0d rd1=%h s2=%0d rd2=%h iv=%0b ird=%0d cr=%0b p=%0b%0b%0b busy=%0b",
             we, wa, wd, s1, bus.readdata1, s2, bus.readdata2, iv, ird, cr,
             bus.pending1, bus.pending2, bus.pending_rd, bus.clear_busy);
    @(posedge clk);
    if (mdl_busy) begin
      mdl_regs[mdl_pos] = '0;
      mdl_pend[mdl_pos] = 1'b0;
      mdl_pos++;
      if (mdl_pos == NR) mdl_busy = 1'b0;
    end else if (cr) begin
      mdl_busy = 1'b1;
      mdl_pos  = 1;
    end else begin
      if (we && wa != 0) begin
        mdl_regs[wa] = wd;
        mdl_pend[wa] = 1'b0;
      end
      if (iv && ird != 0) mdl_pend[ird] = 1'b1;
    end
    #1;
  endtask

  task automatic idle_cycle(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] ird);
    cycle(1'b0, 5'd0, 32'd0, s1, s2, 1'b0, ird, 1'b0);
  endtask

  task automatic fill_all();
    for (int i = 1; i < NR; i++) cycle(1'b1, 5'(i), $urandom | 32'h1, 5'(i), 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  int busy_cycles;

  initial begin
    mdl_reset();
    rst = 1'b0;
    bus.write_enable = 1'b1;
    bus.writedata_add = 5'd5;
    bus.write_data = 32'hCAFE_F00D;
    bus.source1 = 5'd5;
    bus.source2 = 5'd5;
    bus.issue_valid = 1'b0;
    bus.issue_rd = 5'd5;
    bus.clear_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Bypass must stay gated while reset is held.
    check_value("reset_readdata1", bus.readdata1, 32'h0);
    check_value("reset_pending1", {31'b0, bus.pending1}, 32'h0);
    check_value("reset_pending_rd", {31'b0, bus.pending_rd}, 32'h0);
    check_value("reset_clear_busy", {31'b0, bus.clear_busy}, 32'h0);
    rst = 1'b1;

    for (int s = 0; s < NR; s++) idle_cycle(5'(s), 5'(NR - 1 - s), 5'(s));

    cycle(1'b1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd5, 1'b0, 5'd0, 1'b0);
    cycle(1'b1, 5'd5, 32'h12345678, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
    idle_cycle(5'd5, 5'd0, 5'd0);

    cycle(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd7, 1'b0);
    cycle(1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 1'b1, 5'd7, 1'b0);
    cycle(1'b1, 5'd7, 32'hA5, 5'd7, 5'd0, 1'b0, 5'd7, 1'b0);
    idle_cycle(5'd7, 5'd7, 5'd7);

    cycle(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0);
    cycle(1'b1, 5'd9, 32'h99, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0);
    idle_cycle(5'd9, 5'd9, 5'd9);
    cycle(1'b1, 5'd9, 32'h77, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    idle_cycle(5'd9, 5'd9, 5'd9);

    fill_all();
    cycle(1'b0, 5'd0, 32'd0, 5'd3, 5'd4, 1'b1, 5'd3, 1'b0);
    cycle(1'b1, 5'd3, 32'h1111, 5'd3, 5'd4, 1'b1, 5'd4, 1'b1);
    busy_cycles = 0;
    for (int k = 0; k < 40; k++) begin
      if (k == 5) cycle(1'b1, 5'd3, 32'h3333_3333, 5'd3, 5'd2, 1'b1, 5'd3, 1'b1);
      else idle_cycle(5'(k), 5'(NR - 1 - k), 5'(k));
      if (obs_busy) busy_cycles++;
      else break;
    end
    check_value("flush_busy_cycles", 32'(busy_cycles), 32'(NR - 1));
    for (int s = 0; s < NR; s++) idle_cycle(5'(s), 5'(s), 5'(s));

    fill_all();
    cycle(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd30, 1'b1);
    for (int k = 1; k < 10; k++) idle_cycle(5'd31, 5'd20, 5'd31);
    bus.source1 = 5'd31;
    bus.source2 = 5'd20;
    bus.issue_rd = 5'd31;
    bus.write_enable = 1'b0;
    bus.issue_valid = 1'b0;
    bus.clear_req = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_value("midflush_clear_busy", {31'b0, bus.clear_busy}, 32'h0);
    check_value("midflush_readdata1", bus.readdata1, 32'h0);
    check_value("midflush_pending1", {31'b0, bus.pending1}, 32'h0);
    check_value("midflush_pending_rd", {31'b0, bus.pending_rd}, 32'h0);
    mdl_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int s = 0; s < NR; s++) idle_cycle(5'(s), 5'(NR - 1 - s), 5'(s));

    for (int n = 0; n < 500; n++) begin
      logic [4:0] wa, s1, s2, ird;
      wa  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      s1  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      s2  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 7));
      ird = 5'($urandom_range(0, 7));
      cycle(1'($urandom_range(0, 1)), wa, $urandom, s1, s2,
            1'($urandom_range(0, 1)), ird, ($urandom_range(0, 79) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
